// File: rtl/frac_pkg.sv
// Shared constants and divider state encoding for the fractional decimator.
package frac_pkg;
  localparam int BITWIDTH_DEF  = 10;
  localparam int FRACWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;
endpackage

// File: rtl/frac_div_serial.sv
// Serial restoring divider: one quotient bit per cycle, req restarts at any time.
module frac_div_serial
  import frac_pkg::*;
#(
  parameter int DVD_W = 26,
  parameter int DIV_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             ack,
  output logic [DVD_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DVD_W + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [DVD_W-1:0] dvd_q;
  logic [DVD_W-1:0] quo_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W:0]   rem_sh;
  logic [DIV_W-1:0] rem_nxt;
  logic             q_bit;
  logic             last_bit;

  assign last_bit = (cnt_q == CNT_W'(DVD_W - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = IDLE;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (req) state_d = RUN;
  end

  // Remainder stays below the divisor, so the subtraction fits DIV_W bits.
  always_comb begin
    rem_sh  = {rem_q, dvd_q[DVD_W-1]};
    q_bit   = (rem_sh >= {1'b0, div_q});
    rem_nxt = q_bit ? (rem_sh[DIV_W-1:0] - div_q) : rem_sh[DIV_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (req) begin
      cnt_q <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (req) begin
      dvd_q <= dividend;
      div_q <= divisor;
      rem_q <= '0;
      quo_q <= '0;
    end else if (state_q == RUN) begin
      dvd_q <= {dvd_q[DVD_W-2:0], 1'b0};
      rem_q <= rem_nxt;
      quo_q <= {quo_q[DVD_W-2:0], q_bit};
    end
  end

  assign ack      = (state_q == DONE) && !req;
  assign quotient = quo_q;
endmodule

// File: rtl/frac_decim.sv
// Fractional decimator step generator: divides den/num into a fixed-point step and
// walks an accumulator over a span. Define FRAC_DECIM_ROUND_EN for round-to-nearest step.
module frac_decim
  import frac_pkg::*;
#(
  parameter int BITWIDTH  = BITWIDTH_DEF,
  parameter int FRACWIDTH = FRACWIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITWIDTH-1:0]  num,
  input  logic [BITWIDTH-1:0]  den,
  input  logic                 newfraction,
  output logic                 ready,
  input  logic                 step_reset,
  input  logic                 step_in,
  output logic                 step_out,
  output logic [BITWIDTH-1:0]  whole,
  output logic [FRACWIDTH-1:0] fraction,
  output logic                 blank
);
  localparam int W = BITWIDTH + FRACWIDTH;
  localparam logic [W-1:0] ONE = W'(1) << FRACWIDTH;

  function automatic logic [W-1:0] make_dividend(input logic [BITWIDTH-1:0] n,
                                                 input logic [BITWIDTH-1:0] d);
    logic [W-1:0] base;
    base = {d, {FRACWIDTH{1'b0}}};
`ifdef FRAC_DECIM_ROUND_EN
    return base + W'(n >> 1);
`else
    return base + W'(n & '0);
`endif
  endfunction

  // Divide-by-zero gives zero; ratios above one are clamped so whole never skips.
  function automatic logic [W-1:0] clamp_step(input logic [BITWIDTH-1:0] n,
                                              input logic [BITWIDTH-1:0] d,
                                              input logic [W-1:0]        q);
    if (n == '0)     return '0;
    else if (d > n)  return ONE;
    else             return q;
  endfunction

  logic [W-1:0]         quotient;
  logic                 div_ack;
  logic [BITWIDTH-1:0]  num_q, den_q;
  logic [W-1:0]         step_q;
  logic [W-1:0]         acc_q;
  logic [W-1:0]         acc_sum;
  logic                 ready_q;
  logic                 step_out_q;
  logic [BITWIDTH-1:0]  whole_q;
  logic [FRACWIDTH-1:0] frac_q;
  logic                 crossed;
  logic                 advance;

  frac_div_serial #(
    .DVD_W (W),
    .DIV_W (BITWIDTH)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .req      (newfraction),
    .dividend (make_dividend(num, den)),
    .divisor  (num),
    .ack      (div_ack),
    .quotient (quotient)
  );

  assign blank   = (whole_q == den);
  assign acc_sum = acc_q + step_q;
  assign crossed = (acc_sum[W-1:FRACWIDTH] > acc_q[W-1:FRACWIDTH]);
  assign advance = ready_q && step_in && !blank;

  always_ff @(posedge clk) begin
    if (newfraction) begin
      num_q <= num;
      den_q <= den;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      step_q     <= '0;
      acc_q      <= '0;
      whole_q    <= '0;
      frac_q     <= '0;
      step_out_q <= 1'b0;
    end else begin
      step_out_q <= 1'b0;
      if (newfraction) begin
        ready_q <= 1'b0;
        acc_q   <= '0;
        whole_q <= '0;
        frac_q  <= '0;
      end else begin
        if (div_ack) begin
          ready_q <= 1'b1;
          step_q  <= clamp_step(num_q, den_q, quotient);
        end
        if (step_reset) begin
          acc_q   <= '0;
          whole_q <= '0;
          frac_q  <= '0;
        end else if (advance) begin
          acc_q <= acc_sum;
          if (crossed) begin
            step_out_q <= 1'b1;
            whole_q    <= whole_q + BITWIDTH'(1);
            frac_q     <= acc_sum[FRACWIDTH-1:0];
          end else begin
            frac_q <= '0;
          end
        end
      end
    end
  end

  assign ready    = ready_q;
  assign step_out = step_out_q;
  assign whole    = whole_q;
  assign fraction = frac_q;
endmodule

// File: tb/tb_frac_decim.sv
// Directed bench for frac_decim: hand-computed step/whole/fraction sequences.
module tb_frac_decim;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  num, den;
  logic        newfraction, step_reset, step_in;
  logic        ready, step_out, blank;
  logic [9:0]  whole;
  logic [15:0] fraction;

  int checks = 0;
  int errors = 0;

  frac_decim #(.BITWIDTH(10), .FRACWIDTH(16)) dut (
    .clk(clk), .reset(reset), .num(num), .den(den), .newfraction(newfraction),
    .ready(ready), .step_reset(step_reset), .step_in(step_in), .step_out(step_out),
    .whole(whole), .fraction(fraction), .blank(blank)
  );

  always #5 clk = ~clk;

`ifdef FRAC_DECIM_ROUND_EN
  localparam logic [15:0] F32_2 = 16'h5556;
  localparam logic        SO32_3 = 1'b1;
  localparam logic [15:0] F32_3 = 16'h0001;
  localparam logic [9:0]  W32_3 = 10'd2;
  localparam logic        B32_3 = 1'b1;
`else
  localparam logic [15:0] F32_2 = 16'h5554;
  localparam logic        SO32_3 = 1'b0;
  localparam logic [15:0] F32_3 = 16'h0000;
  localparam logic [9:0]  W32_3 = 10'd1;
  localparam logic        B32_3 = 1'b0;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [9:0] n, input logic [9:0] d);
    num = n;
    den = d;
    newfraction = 1'b1;
    cyc();
    newfraction = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    repeat (26) cyc();
    check({tag, "_ready_c26"}, 32'(ready), 32'd0);
    cyc();
    check({tag, "_ready_c27"}, 32'(ready), 32'd1);
  endtask

  task automatic pulse(input string tag, input logic so, input logic [9:0] wh,
                       input logic [15:0] fr);
    step_in = 1'b1;
    cyc();
    step_in = 1'b0;
    check({tag, "_step_out"}, 32'(step_out), 32'(so));
    check({tag, "_whole"}, 32'(whole), 32'(wh));
    check({tag, "_fraction"}, 32'(fraction), 32'(fr));
  endtask

  initial begin
    reset = 1'b1; num = 10'd4; den = 10'd2;
    newfraction = 1'b0; step_reset = 1'b0; step_in = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_step_out", 32'(step_out), 32'd0);
    check("rst_whole", 32'(whole), 32'd0);
    check("rst_fraction", 32'(fraction), 32'd0);
    check("rst_blank_den2", 32'(blank), 32'd0);
    den = 10'd0; #1;
    check("rst_blank_den0", 32'(blank), 32'd1);

    // 4 -> 2 span, step_in ignored while the divider runs
    start(10'd4, 10'd2);
    step_in = 1'b1;
    wait_ready("r42");
    step_in = 1'b0;
    check("ign_whole", 32'(whole), 32'd0);
    check("ign_step_out", 32'(step_out), 32'd0);
    pulse("r42_1", 1'b0, 10'd0, 16'h0);
    pulse("r42_2", 1'b1, 10'd1, 16'h0);
    pulse("r42_3", 1'b0, 10'd1, 16'h0);
    pulse("r42_4", 1'b1, 10'd2, 16'h0);
    check("r42_blank", 32'(blank), 32'd1);
    pulse("r42_blank_in", 1'b0, 10'd2, 16'h0);
    cyc();
    check("r42_pulse_len", 32'(step_out), 32'd0);

    // step_reset, alone and together with step_in
    step_reset = 1'b1; cyc(); step_reset = 1'b0;
    check("srst_whole", 32'(whole), 32'd0);
    check("srst_ready", 32'(ready), 32'd1);
    check("srst_blank", 32'(blank), 32'd0);
    pulse("srst_a", 1'b0, 10'd0, 16'h0);
    step_in = 1'b1; step_reset = 1'b1; cyc(); step_in = 1'b0; step_reset = 1'b0;
    check("both_whole", 32'(whole), 32'd0);
    check("both_step_out", 32'(step_out), 32'd0);
    check("both_ready", 32'(ready), 32'd1);
    pulse("srst_b", 1'b0, 10'd0, 16'h0);
    pulse("srst_c", 1'b1, 10'd1, 16'h0);

    // 3 -> 2 span, truncated or rounded step
    start(10'd3, 10'd2);
    wait_ready("r32");
    pulse("r32_1", 1'b0, 10'd0, 16'h0);
    pulse("r32_2", 1'b1, 10'd1, F32_2);
    pulse("r32_3", SO32_3, W32_3, F32_3);
    check("r32_blank", 32'(blank), 32'(B32_3));

    // abort a running division with new operands 4 -> 1
    start(10'd4, 10'd2);
    check("abort_ready_drop", 32'(ready), 32'd0);
    repeat (9) cyc();
    start(10'd4, 10'd1);
    wait_ready("abort");
    pulse("r41_1", 1'b0, 10'd0, 16'h0);
    pulse("r41_2", 1'b0, 10'd0, 16'h0);
    pulse("r41_3", 1'b0, 10'd0, 16'h0);
    pulse("r41_4", 1'b1, 10'd1, 16'h0);
    check("r41_blank", 32'(blank), 32'd1);

    // reset in cycle 5 of a division
    start(10'd4, 10'd2);
    repeat (4) cyc();
    reset = 1'b1; cyc(); reset = 1'b0;
    check("mrst_ready", 32'(ready), 32'd0);
    check("mrst_whole", 32'(whole), 32'd0);
    check("mrst_fraction", 32'(fraction), 32'd0);
    check("mrst_step_out", 32'(step_out), 32'd0);
    repeat (30) cyc();
    check("mrst_ready_late", 32'(ready), 32'd0);
    pulse("mrst_in", 1'b0, 10'd0, 16'h0);

    // den > num clamps to a unit step
    start(10'd2, 10'd3);
    wait_ready("clamp");
    pulse("clamp_1", 1'b1, 10'd1, 16'h0);
    pulse("clamp_2", 1'b1, 10'd2, 16'h0);
    pulse("clamp_3", 1'b1, 10'd3, 16'h0);
    check("clamp_blank", 32'(blank), 32'd1);

    // num == 0 gives a zero step
    start(10'd0, 10'd5);
    wait_ready("zero");
    for (int i = 0; i < 6; i++) pulse("zero_in", 1'b0, 10'd0, 16'h0);
    check("zero_blank", 32'(blank), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frac_decim.md
FRAC_DECIM -- requirements
Module: frac_decim

Interface
REQ-001 SHALL have parameter BITWIDTH, default 10, width of span counts and whole output.
REQ-002 SHALL have parameter FRACWIDTH, default 16, width of step/fraction.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port num  input  BITWIDTH  source span length (larger value).
REQ-006 SHALL have port den  input  BITWIDTH  destination span length (smaller value).
REQ-007 SHALL have port newfraction  input  1  one-cycle pulse: latch num/den, start division.
REQ-008 SHALL have port ready  output  1  step ratio valid.
REQ-009 SHALL have port step_reset  input  1  restart span (accumulator and counters to zero).
REQ-010 SHALL have port step_in  input  1  one source sample consumed.
REQ-011 SHALL have port step_out  output  1  one-cycle pulse: destination sample completed.
REQ-012 SHALL have port whole  output  BITWIDTH  destination samples emitted in current span.
REQ-013 SHALL have port fraction  output  FRACWIDTH  weight of current source sample carried into the next destination sample.
REQ-014 SHALL have port blank  output  1  span exhausted (whole==den).

Function
REQ-015 On newfraction, SHALL latch num and den and compute step = (den<<FRACWIDTH)/num, width BITWIDTH+FRACWIDTH, truncated.
REQ-016 Division SHALL be serial restoring, one quotient bit per cycle; ready SHALL rise exactly BITWIDTH+FRACWIDTH+1 cycles after newfraction and hold until next newfraction or reset.
REQ-017 newfraction during division SHALL abort and restart with new operands; ready SHALL drop the following cycle.
REQ-018 num==0 SHALL yield step=0 and normal ready timing; den>num SHALL clamp step to 1<<FRACWIDTH.
REQ-019 While ready==0, step_in SHALL be ignored; step_out SHALL be 0.
REQ-020 On step_in with ready==1 and blank==0: acc <= acc+step; if new acc whole part > old whole part, step_out SHALL pulse next cycle, whole SHALL increment, fraction SHALL equal new acc fractional part; otherwise fraction SHALL be 0.
REQ-021 Accumulator SHALL be BITWIDTH+FRACWIDTH bits; it SHALL NOT wrap within a span because whole saturates at den.
REQ-022 When whole==den, blank SHALL be 1, step_in SHALL NOT change acc/whole, step_out SHALL stay 0.
REQ-023 step_reset or newfraction SHALL clear acc, whole, fraction and step_out in the same edge; they SHALL take priority over a simultaneous step_in.
REQ-024 step_reset SHALL NOT clear step or ready.

Reset
REQ-025 reset SHALL force ready=0, step_out=0, whole=0, fraction=0, acc=0, step=0, divider idle; reset overrides all inputs, including mid-division.
REQ-026 blank SHALL be combinational from whole==den (1 after reset when den==0).

Configuration
REQ-027 Macro FRAC_DECIM_ROUND_EN defined: dividend SHALL be (den<<FRACWIDTH)+(num>>1) (round to nearest); undefined: plain truncation per REQ-015; latency unchanged either way.

Structure
REQ-028 Shared package frac_pkg SHALL hold default BITWIDTH/FRACWIDTH constants and the divider state enum (IDLE, RUN, DONE).
REQ-029 Divider SHALL be a sub-module frac_div_serial (req/ack, quotient output); frac_decim holds accumulator, counters and handshake.

Verification
REQ-030 num=4, den=2, newfraction -> ready at cycle 27, step=0x08000; 4 step_in -> step_out after 2nd and 4th, whole 1 then 2, fraction 0, blank=1 after 4th.
REQ-031 num=3, den=2, no macro -> step=0x0AAAA; 3 step_in -> step_out only after 2nd with fraction 0x5554, whole=1 at end, blank=0.
REQ-032 num=3, den=2, FRAC_DECIM_ROUND_EN -> step=0x0AAAB; step_out after 2nd (fraction 0x5556) and 3rd (fraction 0x0001), whole=2, blank=1.
REQ-033 step_in and step_reset same cycle mid-span -> whole=0, acc=0, no step_out; ready stays 1.
REQ-034 newfraction at cycle 10 of a running division with new operands -> ready rises 27 cycles after second newfraction with step for new operands; reset at cycle 5 of division -> ready stays 0, all outputs zero.
REQ-035 num=0, den=5 -> step=0, ready after 27 cycles; any step_in count -> no step_out, whole=0.
